// File: rtl/mul_seq_pkg.sv
// ---------------------------------------------------------------------------
// mul_seq_pkg
// Shared definitions for the iterative multiplier sequencing controller.
//   state_t           : controller state encodings (IDLE/LOAD/RUN/DONE)
//   MODE_R2 / MODE_R4 : multiplication mode constants (radix-2 / radix-4)
// ---------------------------------------------------------------------------
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic MODE_R2 = 1'b0;
    localparam logic MODE_R4 = 1'b1;

endpackage : mul_seq_pkg

// File: rtl/mul_step_counter.sv
// ---------------------------------------------------------------------------
// mul_step_counter
// Step counter for the multiplier sequencer. Counts completed iteration
// steps and flags when the count sits one below the target, so the
// controller can leave RUN on the step that reaches the target.
//   clk       in   clock
//   reset_n   in   asynchronous active-low reset
//   inc_i     in   count one step this cycle
//   clr_i     in   synchronous clear (wins over inc_i)
//   target_i  in   number of steps for the current operation
//   count_o   out  steps completed
//   term_o    out  count_o == target_i - 1
// ---------------------------------------------------------------------------
module mul_step_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] target_i,
    output logic [CNT_W-1:0] count_o,
    output logic             term_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == (target_i - ONE));

endmodule : mul_step_counter

// File: rtl/mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul_seq_ctrl
// Sequencing controller for the iterative shift-add / Booth multiplier.
// A start in IDLE gives one LOAD cycle, then WIDTH (radix-2) or WIDTH/2
// (radix-4) step enables in RUN, then DONE is held until op_clear.
//
// Optional build macro: MUL_SEQ_EARLY_TERM_EN
//   When defined, a step taken while mplr_zero=1 finishes the operation
//   early. When undefined, mplr_zero is ignored (port kept for a fixed
//   interface).
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   op_start   in   start request, sampled in IDLE only
//   op_clear   in   synchronous abort/clear, highest priority
//   mode       in   0 = radix-2, 1 = radix-4; latched on start
//   stall      in   datapath not ready; freezes RUN
//   mplr_zero  in   remaining multiplier bits are zero (early termination)
//   load       out  load operands (the LOAD cycle)
//   step_en    out  perform one iteration step
//   state      out  current state encoding (debug/status)
//   counter    out  steps completed
//   busy       out  high in LOAD or RUN
//   op_done    out  high in DONE
//   done_pulse out  one-cycle pulse on the first DONE cycle
//
// Handshake: step_en is the only step qualifier; the datapath performs a
// step on every cycle where step_en=1, and raising stall withholds step_en
// in that same cycle without losing progress.
// ---------------------------------------------------------------------------
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic             mode,
    input  logic             stall,
    input  logic             mplr_zero,
    output logic             load,
    output logic             step_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] counter,
    output logic             busy,
    output logic             op_done,
    output logic             done_pulse
);

    localparam logic [CNT_W-1:0] T_R2 = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] T_R4 = CNT_W'(WIDTH / 2);

    state_t           state_q;
    logic             mode_q;
    logic             done_pulse_q;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_term;
    logic             cnt_clr;
    logic             finish;

    assign target = (mode_q == MODE_R4) ? T_R4 : T_R2;

    // op_clear masks the datapath strobes in the cycle it is asserted.
    assign load    = (state_q == LOAD) && !op_clear;
    assign step_en = (state_q == RUN) && !stall && !op_clear;

    // Holding the counter clear in IDLE keeps it at zero for a fresh start.
    assign cnt_clr = op_clear || (state_q == IDLE);

`ifdef MUL_SEQ_EARLY_TERM_EN
    assign finish = step_en && (cnt_term || mplr_zero);
`else
    logic unused_mplr_zero;
    assign unused_mplr_zero = mplr_zero;
    assign finish = step_en && cnt_term;
`endif

    mul_step_counter #(
        .CNT_W(CNT_W)
    ) u_step_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc_i    (step_en),
        .clr_i    (cnt_clr),
        .target_i (target),
        .count_o  (cnt_value),
        .term_o   (cnt_term)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mode_q       <= MODE_R2;
            done_pulse_q <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            if (op_clear) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (op_start) begin
                            state_q <= LOAD;
                            mode_q  <= mode;
                        end
                    end
                    LOAD: state_q <= RUN;
                    RUN: begin
                        if (finish) begin
                            state_q      <= DONE;
                            done_pulse_q <= 1'b1;
                        end
                    end
                    DONE:    state_q <= DONE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign state      = state_q;
    assign counter    = cnt_value;
    assign busy       = (state_q == LOAD) || (state_q == RUN);
    assign op_done    = (state_q == DONE);
    assign done_pulse = done_pulse_q;

endmodule : mul_seq_ctrl

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int NCYC  = 64;

    logic             clk;
    logic             reset_n;
    logic             op_start;
    logic             op_clear;
    logic             mode;
    logic             stall;
    logic             mplr_zero;
    logic             load;
    logic             step_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic             busy;
    logic             op_done;
    logic             done_pulse;

    int checks;
    int errors;

    // Per-cycle trace, sampled mid-cycle.
    logic             load_a [NCYC];
    logic             step_a [NCYC];
    logic             busy_a [NCYC];
    logic             dp_a   [NCYC];
    logic             done_a [NCYC];
    logic [1:0]       st_a   [NCYC];
    logic [CNT_W-1:0] cnt_a  [NCYC];

    mul_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op_start   (op_start),
        .op_clear   (op_clear),
        .mode       (mode),
        .stall      (stall),
        .mplr_zero  (mplr_zero),
        .load       (load),
        .step_en    (step_en),
        .state      (state),
        .counter    (counter),
        .busy       (busy),
        .op_done    (op_done),
        .done_pulse (done_pulse)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Called at posedge+1: drives one cycle, samples at mid-cycle, returns
    // at the next posedge+1.
    task automatic do_cycle(input int c, input logic s, input logic clr,
                            input logic md, input logic stl, input logic mz);
        op_start  = s;
        op_clear  = clr;
        mode      = md;
        stall     = stl;
        mplr_zero = mz;
        #3;
        load_a[c] = load;
        step_a[c] = step_en;
        busy_a[c] = busy;
        dp_a[c]   = done_pulse;
        done_a[c] = op_done;
        st_a[c]   = state;
        cnt_a[c]  = counter;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        do_cycle(NCYC - 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        op_clear = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n   = 1'b0;
        op_start  = 1'b0;
        op_clear  = 1'b0;
        mode      = 1'b0;
        stall     = 1'b0;
        mplr_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (state !== 2'b00 || counter !== 6'd0 || load !== 1'b0 || step_en !== 1'b0 ||
            busy !== 1'b0 || op_done !== 1'b0 || done_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got st=%b cnt=%0d ld=%b se=%b bsy=%b dn=%b dp=%b, expected all zero",
                     state, counter, load, step_en, busy, op_done, done_pulse);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_radix2();
        int n_step, n_load, n_busy, n_dp;
        for (int c = 0; c < 37; c++) do_cycle(c, c == 0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_step = 0; n_load = 0; n_busy = 0; n_dp = 0;
        for (int c = 0; c < 37; c++) begin
            n_step += int'(step_a[c]);
            n_load += int'(load_a[c]);
            n_busy += int'(busy_a[c]);
            n_dp   += int'(dp_a[c]);
        end
        checks++;
        if (load_a[1] !== 1'b1 || n_load != 1) begin
            errors++; $display("FAIL r2_load: load@c1=%b count=%0d, expected 1 and 1", load_a[1], n_load);
        end
        checks++;
        if (n_step != 32 || step_a[2] !== 1'b1 || step_a[33] !== 1'b1 || step_a[34] !== 1'b0) begin
            errors++; $display("FAIL r2_steps: count=%0d c2=%b c33=%b c34=%b, expected 32 1 1 0",
                               n_step, step_a[2], step_a[33], step_a[34]);
        end
        checks++;
        if (st_a[33] !== 2'b10 || cnt_a[33] !== 6'd31) begin
            errors++; $display("FAIL r2_last_run: st=%b cnt=%0d, expected 10 31", st_a[33], cnt_a[33]);
        end
        checks++;
        if (st_a[34] !== 2'b11 || cnt_a[34] !== 6'd32 || done_a[34] !== 1'b1) begin
            errors++; $display("FAIL r2_done: st=%b cnt=%0d done=%b, expected 11 32 1", st_a[34], cnt_a[34], done_a[34]);
        end
        checks++;
        if (n_dp != 1 || dp_a[34] !== 1'b1) begin
            errors++; $display("FAIL r2_done_pulse: count=%0d c34=%b, expected 1 1", n_dp, dp_a[34]);
        end
        checks++;
        if (n_busy != 33 || busy_a[1] !== 1'b1 || busy_a[33] !== 1'b1 || busy_a[0] !== 1'b0) begin
            errors++; $display("FAIL r2_busy: count=%0d c0=%b c1=%b c33=%b, expected 33 0 1 1",
                               n_busy, busy_a[0], busy_a[1], busy_a[33]);
        end
    endtask

    // Continues from DONE: op_start held must not restart, then op_clear.
    task automatic test_done_hold_and_clear();
        int n_dp;
        n_dp = 0;
        for (int c = 0; c < 5; c++) do_cycle(c, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) n_dp += int'(dp_a[c]);
        checks++;
        if (st_a[4] !== 2'b11 || cnt_a[4] !== 6'd32 || n_dp != 0 || load_a[0] !== 1'b0) begin
            errors++; $display("FAIL done_ignore_start: st=%b cnt=%0d dp=%0d ld=%b, expected 11 32 0 0",
                               st_a[4], cnt_a[4], n_dp, load_a[0]);
        end
        do_cycle(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        op_clear = 1'b0;
        checks++;
        if (state !== 2'b00 || counter !== 6'd0 || op_done !== 1'b0) begin
            errors++; $display("FAIL done_clear: st=%b cnt=%0d done=%b, expected 00 0 0", state, counter, op_done);
        end
    endtask

    task automatic test_radix4_mode_toggle();
        int n_step;
        n_step = 0;
        // mode=1 at start, then toggles every cycle.
        for (int c = 0; c < 22; c++) do_cycle(c, c == 0, 1'b0, (c % 2) == 0, 1'b0, 1'b0);
        for (int c = 0; c < 22; c++) n_step += int'(step_a[c]);
        checks++;
        if (n_step != 16 || step_a[17] !== 1'b1 || step_a[18] !== 1'b0) begin
            errors++; $display("FAIL r4_steps: count=%0d c17=%b c18=%b, expected 16 1 0", n_step, step_a[17], step_a[18]);
        end
        checks++;
        if (st_a[18] !== 2'b11 || cnt_a[18] !== 6'd16 || dp_a[18] !== 1'b1 || cnt_a[21] !== 6'd16) begin
            errors++; $display("FAIL r4_done: st=%b cnt=%0d dp=%b cnt_late=%0d, expected 11 16 1 16",
                               st_a[18], cnt_a[18], dp_a[18], cnt_a[21]);
        end
        go_idle();
    endtask

    task automatic test_stall();
        int n_step;
        n_step = 0;
        // Counter is 5 during c7; stall c7..c9.
        for (int c = 0; c < 40; c++) do_cycle(c, c == 0, 1'b0, 1'b0, (c >= 7 && c <= 9), 1'b0);
        stall = 1'b0;
        for (int c = 0; c < 40; c++) n_step += int'(step_a[c]);
        checks++;
        if (cnt_a[7] !== 6'd5 || cnt_a[9] !== 6'd5 || cnt_a[10] !== 6'd5 ||
            step_a[7] !== 1'b0 || step_a[8] !== 1'b0 || step_a[9] !== 1'b0 || st_a[9] !== 2'b10) begin
            errors++; $display("FAIL stall_hold: cnt7=%0d cnt10=%0d se7..9=%b%b%b st9=%b, expected 5 5 000 10",
                               cnt_a[7], cnt_a[10], step_a[7], step_a[8], step_a[9], st_a[9]);
        end
        checks++;
        if (n_step != 32 || st_a[36] !== 2'b10 || st_a[37] !== 2'b11 || dp_a[37] !== 1'b1 || cnt_a[37] !== 6'd32) begin
            errors++; $display("FAIL stall_total: steps=%0d st36=%b st37=%b dp37=%b cnt37=%0d, expected 32 10 11 1 32",
                               n_step, st_a[36], st_a[37], dp_a[37], cnt_a[37]);
        end
        go_idle();
    endtask

    task automatic test_clear_in_run();
        // Counter is 10 during c12; clear there.
        for (int c = 0; c < 14; c++) do_cycle(c, c == 0, c == 12, 1'b0, 1'b0, 1'b0);
        op_clear = 1'b0;
        checks++;
        if (cnt_a[12] !== 6'd10 || step_a[12] !== 1'b0 || step_a[11] !== 1'b1) begin
            errors++; $display("FAIL clear_run_step: cnt=%0d se12=%b se11=%b, expected 10 0 1", cnt_a[12], step_a[12], step_a[11]);
        end
        checks++;
        if (st_a[13] !== 2'b00 || cnt_a[13] !== 6'd0 || busy_a[13] !== 1'b0) begin
            errors++; $display("FAIL clear_run_idle: st=%b cnt=%0d busy=%b, expected 00 0 0", st_a[13], cnt_a[13], busy_a[13]);
        end
    endtask

    task automatic test_start_with_clear();
        do_cycle(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_cycle(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (st_a[1] !== 2'b00 || load_a[1] !== 1'b0 || busy_a[1] !== 1'b0) begin
            errors++; $display("FAIL start_clear_idle: st=%b ld=%b busy=%b, expected 00 0 0", st_a[1], load_a[1], busy_a[1]);
        end
    endtask

    task automatic test_async_reset();
        logic [CNT_W-1:0] cnt_before;
        for (int c = 0; c < 22; c++) do_cycle(c, c == 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt_before = counter;
        checks++;
        if (cnt_before !== 6'd20 || state !== 2'b10) begin
            errors++; $display("FAIL areset_pre: cnt=%0d st=%b, expected 20 10", cnt_before, state);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'b00 || counter !== 6'd0 || step_en !== 1'b0 || load !== 1'b0 ||
            busy !== 1'b0 || op_done !== 1'b0 || done_pulse !== 1'b0) begin
            errors++; $display("FAIL areset_immediate: st=%b cnt=%0d se=%b ld=%b bsy=%b, expected 00 0 0 0 0",
                               state, counter, step_en, load, busy);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (state !== 2'b00 || counter !== 6'd0) begin
            errors++; $display("FAIL areset_after: st=%b cnt=%0d, expected 00 0", state, counter);
        end
    endtask

    task automatic test_early_term();
        int n_step, n_dp;
        n_step = 0; n_dp = 0;
        // Counter is 7 during c9; mplr_zero asserted from c9 onward.
        for (int c = 0; c < 37; c++) do_cycle(c, c == 0, 1'b0, 1'b0, 1'b0, c >= 9);
        mplr_zero = 1'b0;
        for (int c = 0; c < 37; c++) begin
            n_step += int'(step_a[c]);
            n_dp   += int'(dp_a[c]);
        end
`ifdef MUL_SEQ_EARLY_TERM_EN
        checks++;
        if (st_a[10] !== 2'b11 || cnt_a[10] !== 6'd8 || n_step != 8 || n_dp != 1 || dp_a[10] !== 1'b1) begin
            errors++; $display("FAIL early_term: st10=%b cnt10=%0d steps=%0d dp=%0d, expected 11 8 8 1",
                               st_a[10], cnt_a[10], n_step, n_dp);
        end
`else
        checks++;
        if (st_a[10] !== 2'b10 || st_a[34] !== 2'b11 || cnt_a[34] !== 6'd32 || n_step != 32 || n_dp != 1) begin
            errors++; $display("FAIL no_early_term: st10=%b st34=%b cnt34=%0d steps=%0d dp=%0d, expected 10 11 32 32 1",
                               st_a[10], st_a[34], cnt_a[34], n_step, n_dp);
        end
`endif
        go_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_radix2();
        test_done_hold_and_clear();
        test_radix4_mode_toggle();
        test_stall();
        test_clear_in_run();
        test_start_with_clear();
        test_async_reset();
        test_early_term();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mul_seq_ctrl
